// File: rtl/raster_scan_if.sv
// Control inputs and raster/tile outputs of raster_scan_gen, grouped as one bus.
interface raster_scan_if #(
  parameter int XW  = 10,
  parameter int YW  = 10,
  parameter int TW  = 7,
  parameter int FCW = 8
);
  logic           start;
  logic           abort;
  logic           en;
  logic           oneshot;
  logic [XW-1:0]  xpos;
  logic [YW-1:0]  ypos;
  logic [TW-1:0]  xtile;
  logic [TW-1:0]  ytile;
  logic           tile_valid;
  logic           active;
  logic           hblank;
  logic           vblank;
  logic           line_start;
  logic           frame_start;
  logic           frame_done;
  logic [FCW-1:0] frame_count;
  logic           busy;

  modport master (
    output start, abort, en, oneshot,
    input  xpos, ypos, xtile, ytile, tile_valid, active, hblank, vblank,
           line_start, frame_start, frame_done, frame_count, busy
  );

  modport slave (
    input  start, abort, en, oneshot,
    output xpos, ypos, xtile, ytile, tile_valid, active, hblank, vblank,
           line_start, frame_start, frame_done, frame_count, busy
  );
endinterface

// File: rtl/raster_scan_gen.sv
// Raster position sequencer: walks (xpos, ypos) over active+blank geometry and
// derives maze tile coordinates, with stall, one-shot/free-run and frame counting.
//
// state | meaning
// IDLE  | stopped at (0,0), waiting for start
// SCAN  | walking the raster, advancing one pixel per enabled cycle
// HOLD  | one-shot frame finished, parked at (0,0) until start
module raster_scan_gen #(
  parameter int XW            = 10,
  parameter int YW            = 10,
  parameter int H_ACTIVE      = 160,
  parameter int H_BLANK       = 0,
  parameter int V_ACTIVE      = 320,
  parameter int V_BLANK       = 0,
  parameter int TILE_SHIFT    = 3,
  parameter int TILE_Y_OFFSET = 3,
  parameter int TW            = 7,
  parameter int FCW           = 8
) (
  input logic          clk,
  input logic          rst,
  raster_scan_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;

  if (H_TOTAL < 1 || H_TOTAL > (1 << XW) || V_TOTAL < 1 || V_TOTAL > (1 << YW)) begin : g_bad_geometry
    $error("raster_scan_gen: H_TOTAL/V_TOTAL do not fit in XW/YW");
  end

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  // one extra bit so an active width equal to 2**XW still compares correctly
  localparam logic [XW:0]   X_ACT  = (XW+1)'(H_ACTIVE);
  localparam logic [YW:0]   Y_ACT  = (YW+1)'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t         state, state_n;
  logic [XW-1:0]  x_q, x_n;
  logic [YW-1:0]  y_q, y_n;
  logic [FCW-1:0] fc_q, fc_n;
  logic           fd_q, fd_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      fc_q  <= '0;
      fd_q  <= 1'b0;
    end else begin
      state <= state_n;
      x_q   <= x_n;
      y_q   <= y_n;
      fc_q  <= fc_n;
      fd_q  <= fd_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    fc_n    = fc_q;
    fd_n    = 1'b0;
    if (bus.abort) begin
      state_n = IDLE;
      x_n     = '0;
      y_n     = '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (bus.start) state_n = SCAN;
        end
        SCAN: begin
          if (bus.en) begin
            if (x_q != X_LAST) begin
              x_n = x_q + 1'b1;
            end else begin
              x_n = '0;
              if (y_q != Y_LAST) begin
                y_n = y_q + 1'b1;
              end else begin
                y_n  = '0;
                fc_n = fc_q + 1'b1;
                fd_n = 1'b1;
                if (bus.oneshot) state_n = HOLD;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic          scan;
  logic          act;
  logic [YW-1:0] ycell;

  assign scan  = (state == SCAN);
  assign act   = scan && ({1'b0, x_q} < X_ACT) && ({1'b0, y_q} < Y_ACT);
  assign ycell = y_q >> TILE_SHIFT;

  assign bus.xpos        = x_q;
  assign bus.ypos        = y_q;
  assign bus.busy        = scan;
  assign bus.active      = act;
  assign bus.hblank      = scan && ({1'b0, x_q} >= X_ACT);
  assign bus.vblank      = scan && ({1'b0, y_q} >= Y_ACT);
  assign bus.line_start  = scan && (x_q == '0);
  assign bus.frame_start = scan && (x_q == '0) && (y_q == '0);
  assign bus.frame_done  = fd_q;
  assign bus.frame_count = fc_q;
  assign bus.xtile       = TW'(x_q >> TILE_SHIFT);
  // HUD rows sit above the maze, so rows above the offset wrap modulo 2**TW
  assign bus.ytile       = TW'(32'(ycell) - TILE_Y_OFFSET);
  assign bus.tile_valid  = act && (32'(ycell) >= TILE_Y_OFFSET);
endmodule

// File: tb/tb_raster_scan_gen.sv
// Scoreboard bench: two geometries driven in lockstep, each checked against a
// linear-pixel-index reference model every cycle.
module tb_raster_scan_gen;
  logic clk;
  logic rst;
  logic r_start, r_abort, r_en, r_oneshot;

  raster_scan_if #(.XW(10), .YW(10), .TW(7), .FCW(8)) bus_a ();
  raster_scan_if #(.XW(10), .YW(10), .TW(7), .FCW(2)) bus_b ();

  assign bus_a.start = r_start;  assign bus_a.abort = r_abort;
  assign bus_a.en    = r_en;     assign bus_a.oneshot = r_oneshot;
  assign bus_b.start = r_start;  assign bus_b.abort = r_abort;
  assign bus_b.en    = r_en;     assign bus_b.oneshot = r_oneshot;

  raster_scan_gen dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  raster_scan_gen #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .V_BLANK(2), .FCW(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  xt;
    logic [7:0]  yt;
    logic        tv, act, hb, vb, ls, fs, fd;
    logic [7:0]  fc;
    logic        busy;
  } obs_t;

  typedef struct { int ha; int hb; int va; int vb; int fcw; } geom_t;
  // mode: 0 idle, 1 scanning, 2 holding after a one-shot frame
  typedef struct { int mode; int pix; int fc; bit fd; } mdl_t;

  geom_t ga = '{160, 0, 320, 0, 8};
  geom_t gb = '{8, 4, 4, 2, 2};
  mdl_t  ma, mb;
  mdl_t  m_reset = '{0, 0, 0, 1'b0};

  obs_t qa[$];
  obs_t qb[$];

  int checks = 0;
  int failures = 0;
  bit win = 0;
  int b_act = 0;
  int b_fd = 0;

  function automatic mdl_t model_edge(mdl_t m, geom_t g, bit s, bit a, bit e, bit o);
    mdl_t n = m;
    n.fd = 1'b0;
    if (a) begin
      n.mode = 0;
      n.pix  = 0;
    end else if (m.mode != 1) begin
      if (s) n.mode = 1;
    end else if (e) begin
      n.pix = m.pix + 1;
      if (n.pix == (g.ha + g.hb) * (g.va + g.vb)) begin
        n.pix = 0;
        n.fc  = (m.fc + 1) % (1 << g.fcw);
        n.fd  = 1'b1;
        if (o) n.mode = 2;
      end
    end
    return n;
  endfunction

  function automatic obs_t model_obs(mdl_t m, geom_t g);
    obs_t o;
    int ht = g.ha + g.hb;
    int x = m.pix % ht;
    int y = m.pix / ht;
    bit scan = (m.mode == 1);
    o.x    = 16'(x);
    o.y    = 16'(y);
    o.xt   = 8'((x / 8) % 128);
    o.yt   = 8'(((y / 8) - 3) & 127);
    o.act  = scan && x < g.ha && y < g.va;
    o.tv   = o.act && (y / 8) >= 3;
    o.hb   = scan && x >= g.ha;
    o.vb   = scan && y >= g.va;
    o.ls   = scan && x == 0;
    o.fs   = scan && m.pix == 0;
    o.fd   = m.fd;
    o.fc   = 8'(m.fc);
    o.busy = scan;
    return o;
  endfunction

  task automatic step(input logic r, input logic s, input logic a, input logic e, input logic o);
    @(posedge clk);
    #1;
    if (rst) begin
      ma = m_reset;
      mb = m_reset;
    end else begin
      ma = model_edge(ma, ga, r_start, r_abort, r_en, r_oneshot);
      mb = model_edge(mb, gb, r_start, r_abort, r_en, r_oneshot);
    end
    qa.push_back(model_obs(ma, ga));
    qb.push_back(model_obs(mb, gb));
    rst = r; r_start = s; r_abort = a; r_en = e; r_oneshot = o;
  endtask

  // reset pulse that begins and ends between clock edges
  task automatic pulse_rst();
    @(negedge clk);
    #1;
    r_start = 0; r_abort = 0; r_en = 0; r_oneshot = 0;
    rst = 1;
    ma = m_reset;
    mb = m_reset;
    #2 rst = 0;
  endtask

  always @(negedge clk) begin
    obs_t ea, eb, aa, ab;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      aa = '{x: 16'(bus_a.xpos), y: 16'(bus_a.ypos), xt: 8'(bus_a.xtile), yt: 8'(bus_a.ytile),
             tv: bus_a.tile_valid, act: bus_a.active, hb: bus_a.hblank, vb: bus_a.vblank,
             ls: bus_a.line_start, fs: bus_a.frame_start, fd: bus_a.frame_done,
             fc: 8'(bus_a.frame_count), busy: bus_a.busy};
      checks++;
      if (aa !== ea) begin
        failures++;
        $display("FAIL dut_a_obs t=%0t got x=%0d y=%0d all=%h expected x=%0d y=%0d all=%h",
                 $time, aa.x, aa.y, aa, ea.x, ea.y, ea);
      end
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      ab = '{x: 16'(bus_b.xpos), y: 16'(bus_b.ypos), xt: 8'(bus_b.xtile), yt: 8'(bus_b.ytile),
             tv: bus_b.tile_valid, act: bus_b.active, hb: bus_b.hblank, vb: bus_b.vblank,
             ls: bus_b.line_start, fs: bus_b.frame_start, fd: bus_b.frame_done,
             fc: 8'(bus_b.frame_count), busy: bus_b.busy};
      checks++;
      if (ab !== eb) begin
        failures++;
        $display("FAIL dut_b_obs t=%0t got x=%0d y=%0d all=%h expected x=%0d y=%0d all=%h",
                 $time, ab.x, ab.y, ab, eb.x, eb.y, eb);
      end
    end
    if (win) begin
      b_act += int'(bus_b.active);
      b_fd  += int'(bus_b.frame_done);
    end
  end

  initial begin
    rst = 1; r_start = 0; r_abort = 0; r_en = 0; r_oneshot = 0;
    ma = m_reset;
    mb = m_reset;

    // full default one-shot frame after an async reset pulse
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    pulse_rst();
    step(0, 1, 0, 1, 1);
    repeat (51210) step(0, 0, 0, 1, 1);

    // free-running small geometry: 5 frames of 72 cycles from a clean count
    pulse_rst();
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    win = 1;
    repeat (360) step(0, 0, 0, 1, 0);
    win = 0;
    checks++;
    if (b_act != 160) begin
      failures++;
      $display("FAIL b_active_count got=%0d expected=160", b_act);
    end
    checks++;
    if (b_fd != 5) begin
      failures++;
      $display("FAIL b_frame_done_count got=%0d expected=5", b_fd);
    end

    // stall: enable toggles every cycle
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 200; i++) step(0, 0, 0, i % 2 == 0, 0);

    // abort together with start at (50,10) on the default geometry
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    repeat (1650) step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    repeat (20) step(0, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) pulse_rst();
      step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/raster_scan_gen.md
Name: raster_scan_gen

Overview:
Parametrised pixel-position sequencer that produces the (xpos, ypos) raster walk consumed by the maze renderer and sprite blocks. It adds configurable active/blanking geometry, a pixel-enable stall, continuous or one-shot frame modes, and a frame counter. It also derives pacman-style tile coordinates (pixel >> shift, with a row offset for the HUD rows) so downstream blocks can index the maze directly.

Parameters:
XW, 10, width of xpos
YW, 10, width of ypos
H_ACTIVE, 160, visible pixels per line
H_BLANK, 0, blank pixels per line after active
V_ACTIVE, 320, visible lines per frame
V_BLANK, 0, blank lines per frame after active
TILE_SHIFT, 3, log2 of tile size in pixels
TILE_Y_OFFSET, 3, tile rows above the maze (HUD)
TW, 7, width of tile coordinates
FCW, 8, width of frame_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin scanning from IDLE or HOLD
abort  in  1  synchronous return to IDLE
en  in  1  pixel-advance enable (stall when 0)
oneshot  in  1  1 = stop after the current frame; 0 = free-run
xpos  out  XW  current x (registered)
ypos  out  YW  current y (registered)
xtile  out  TW  xpos >> TILE_SHIFT
ytile  out  TW  (ypos >> TILE_SHIFT) - TILE_Y_OFFSET, truncated to TW
tile_valid  out  1  active and (ypos >> TILE_SHIFT) >= TILE_Y_OFFSET
active  out  1  inside visible region
hblank  out  1  scanning and xpos >= H_ACTIVE
vblank  out  1  scanning and ypos >= V_ACTIVE
line_start  out  1  scanning and xpos == 0
frame_start  out  1  scanning and xpos == 0 and ypos == 0
frame_done  out  1  one-cycle pulse after the last pixel of a frame
frame_count  out  FCW  completed frames, wraps modulo 2^FCW
busy  out  1  state == SCAN

Behaviour:
- H_TOTAL = H_ACTIVE + H_BLANK; V_TOTAL = V_ACTIVE + V_BLANK. Both must fit in XW/YW (elaboration-time check).
- States: IDLE, SCAN, HOLD. On async rst: IDLE, xpos=0, ypos=0, frame_count=0, frame_done=0. All combinational outputs are therefore 0 except xtile=0 and ytile=-TILE_Y_OFFSET mod 2^TW. No combinational outputs are qualified by rst.
- Priority each clock edge: abort > start > en-advance.
- abort=1 in any state: next state IDLE, xpos=ypos=0, frame_done=0. frame_count is kept.
- IDLE/HOLD + start=1: next state SCAN. Counters stay 0,0; the first pixel is presented for at least one cycle.
- SCAN with en=0: all registers hold. frame_done still deasserts after its one cycle.
- SCAN with en=1:
  - xpos < H_TOTAL-1: xpos++.
  - xpos == H_TOTAL-1 and ypos < V_TOTAL-1: xpos=0, ypos++.
  - xpos == H_TOTAL-1 and ypos == V_TOTAL-1 (frame wrap): xpos=0, ypos=0, frame_count++, frame_done=1 next cycle. Next state is HOLD if oneshot=1 (sampled on that edge), else SCAN.
- start while already in SCAN: ignored.
- oneshot may change at any time; only its value at the wrap edge matters.
- active = busy and xpos < H_ACTIVE and ypos < V_ACTIVE.
- line_start, frame_start, hblank, vblank and active are all 0 outside SCAN.
- Tile math is unsigned, taken from the registered counters; no extra latency versus xpos/ypos.
- frame_count wraps 2^FCW-1 -> 0 with no flag.

Test Plan:
- Defaults, rst pulse mid-cycle (async), then start, en=1, oneshot=1 -> xpos 0..159 per line, ypos 0..319; frame_done high exactly one cycle after (159,319); state HOLD with (0,0); frame_count=1; total 51200 advancing cycles.
- H_BLANK=4, V_BLANK=2, H_ACTIVE=8, V_ACTIVE=4, oneshot=0 -> hblank at x=8..11, vblank at y=4..5, active count 32 per frame, frame_count increments every 72 enabled cycles.
- en toggled 1/0 alternately -> each position held for 2 cycles; frame_done still exactly 1 cycle wide.
- Defaults, pos (119,227) -> xtile=14, ytile=25, tile_valid=1; at y=16 -> ytile=127 (wrap), tile_valid=0.
- abort at (50,10) together with start -> IDLE, (0,0), busy=0, frame_count unchanged; start next cycle -> SCAN from (0,0).
- FCW=2, oneshot=0, 5 frames -> frame_count sequence 1,2,3,0,1.
